// File: rtl/miriscv_imm_enc.sv
// miriscv_imm_enc: RV32I instruction encoder with LI (LUI/ADDI) expansion on a valid/ready stream.
// Define MIRISCV_IMM_ENC_CHECK_EN to build the immediate range check that drives range_err_o.
module miriscv_imm_enc #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [4:0]      req_opcode_i,
   input  logic [4:0]      req_rd_i,
   input  logic [4:0]      req_rs1_i,
   input  logic [4:0]      req_rs2_i,
   input  logic [2:0]      req_funct3_i,
   input  logic [6:0]      req_funct7_i,
   input  logic [XLEN-1:0] req_imm_i,
   input  logic            req_li_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic            instr_last_o,
   output logic            range_err_o
);
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_OPIMM  = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   typedef enum logic {IDLE, LI_LO} state_t;
   state_t state;
   logic [4:0]  li_rd_q;
   logic [11:0] li_lo_q;
   logic [31:0] imm, enc, li_word, addi_word;
   logic [19:0] li_hi;
   logic        is_i, is_s, is_b, is_u, is_j, li_two, enc_err;
   assign imm  = req_imm_i;
   assign is_i = req_opcode_i == OP_OPIMM || req_opcode_i == OP_LOAD || req_opcode_i == OP_JALR;
   assign is_s = req_opcode_i == OP_STORE;
   assign is_b = req_opcode_i == OP_BRANCH;
   assign is_u = req_opcode_i == OP_LUI || req_opcode_i == OP_AUIPC;
   assign is_j = req_opcode_i == OP_JAL;
   always_comb begin
      enc = is_i ? {imm[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i, 2'b11}
          : is_s ? {imm[11:5], req_rs2_i, req_rs1_i, req_funct3_i, imm[4:0], req_opcode_i, 2'b11}
          : is_b ? {imm[12], imm[10:5], req_rs2_i, req_rs1_i, req_funct3_i, imm[4:1], imm[11], req_opcode_i, 2'b11}
          : is_u ? {imm[31:12], req_rd_i, req_opcode_i, 2'b11}
          : is_j ? {imm[20], imm[10:1], imm[11], imm[19:12], req_rd_i, req_opcode_i, 2'b11}
          : {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i, 2'b11};
   end
   // (imm + 0x800) >> 12 rounds hi so that the sign-extended ADDI lo lands exactly on imm
   assign li_hi     = imm[31:12] + {19'd0, imm[11]};
   assign li_two    = req_rd_i != 5'd0 && li_hi != 20'd0 && imm[11:0] != 12'd0;
   assign li_word   = req_rd_i == 5'd0 ? 32'h0000_0013
                    : li_hi == 20'd0 ? {imm[11:0], 5'd0, 3'd0, req_rd_i, OP_OPIMM, 2'b11}
                    : {li_hi, req_rd_i, OP_LUI, 2'b11};
   assign addi_word = {li_lo_q, li_rd_q, 3'd0, li_rd_q, OP_OPIMM, 2'b11};
`ifdef MIRISCV_IMM_ENC_CHECK_EN
   assign enc_err = (is_i || is_s) ? imm != {{20{imm[11]}}, imm[11:0]}
                  : is_b ? imm[0] || imm != {{19{imm[12]}}, imm[12:0]}
                  : is_j ? imm[0] || imm != {{11{imm[20]}}, imm[20:0]}
                  : is_u ? imm[11:0] != 12'd0
                  : 1'b0;
`else
   assign enc_err = 1'b0;
`endif
   assign req_ready_o = state == IDLE && (!instr_valid_o || instr_ready_i);
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= IDLE;
         instr_valid_o <= 1'b0;
         instr_o       <= '0;
         instr_last_o  <= 1'b0;
         range_err_o   <= 1'b0;
         li_rd_q       <= '0;
         li_lo_q       <= '0;
      end else if (state == LI_LO) begin
         if (instr_ready_i) begin
            instr_o      <= addi_word;
            instr_last_o <= 1'b1;
            range_err_o  <= 1'b0;
            state        <= IDLE;
         end
      end else if (req_valid_i && req_ready_o) begin
         instr_valid_o <= 1'b1;
         instr_o       <= req_li_i ? li_word : enc;
         instr_last_o  <= !(req_li_i && li_two);
         range_err_o   <= !req_li_i && enc_err;
         li_rd_q       <= req_rd_i;
         li_lo_q       <= imm[11:0];
         state         <= (req_li_i && li_two) ? LI_LO : IDLE;
      end else if (instr_ready_i) begin
         instr_valid_o <= 1'b0;
      end
   end
endmodule

// File: doc/miriscv_imm_enc.md
Name: miriscv_imm_enc

Overview:
- Instruction assembler for RV32I; the inverse of the immediate decoder in the decode stage.
- Takes opcode, register fields, funct fields and a 32-bit immediate, and emits the encoded 32-bit instruction word on a valid/ready stream.
- Also expands the LI pseudo-op into LUI/ADDI, emitting one or two words.
- Used by the debug/boot instruction injector and by the self-check bench to build stimulus.

Parameters:
- XLEN, 32, data/instruction width; only 32 is supported.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_opcode_i  in  5  instr[6:2] opcode, miriscv_opcodes_pkg S_OPCODE_* values
- req_rd_i  in  5  destination register
- req_rs1_i  in  5  source register 1
- req_rs2_i  in  5  source register 2
- req_funct3_i  in  3  funct3
- req_funct7_i  in  7  funct7 (R-type only)
- req_imm_i  in  XLEN  immediate as the decoder would output it (byte offset for B/J; value with low 12 bits for U)
- req_li_i  in  1  LI pseudo-op: load req_imm_i into rd; opcode/funct ignored
- instr_valid_o  out  1  output word valid
- instr_ready_i  in  1  consumer ready
- instr_o  out  XLEN  encoded instruction, low 2 bits always 2'b11
- instr_last_o  out  1  last word of the current request
- range_err_o  out  1  immediate not representable in the format (qualified by instr_valid_o)

Behaviour:
- Reset values: instr_valid_o=0, instr_o=0, instr_last_o=0, range_err_o=0, FSM=IDLE. Reset mid-request drops any pending second LI word.
- Format by opcode:
  - OPIMM/LOAD/JALR: I-type; instr[31:20]=imm[11:0].
  - STORE: S-type; [31:25]=imm[11:5], [11:7]=imm[4:0].
  - BRANCH: B-type; [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - LUI/AUIPC: U-type; [31:12]=imm[31:12].
  - JAL: J-type; [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - All other opcodes: R-type layout, imm ignored.
  - Fields not used by a format are zero.
- Output stage is a single registered slot. Latency from accept to instr_valid_o is 1 cycle.
- req_ready_o = (state==IDLE) && (!instr_valid_o || instr_ready_i). This is combinational from instr_ready_i and gives full throughput for single-word requests.
- Word hold: while instr_valid_o && !instr_ready_i, instr_o, instr_last_o and range_err_o hold stable.
- FSM states:
  - IDLE: on accept of a non-LI request, or an LI request needing one word, load the slot with last=1 and stay in IDLE.
  - IDLE → LI_LO: on accept of an LI request needing two words, load LUI with last=0 and latch rd/lo.
  - LI_LO: when the slot is consumed, load ADDI rd,rd,lo with last=1 and return to IDLE. The ADDI appears the cycle after LUI handshake; no bubble occurs if the consumer stays ready.
- LI split:
  - lo = sext(imm[11:0]); hi = (imm + 32'h800)[31:12], computed mod 2^32.
  - rd==0: single NOP (0x00000013).
  - hi==0: single ADDI rd,x0,lo.
  - lo==0: single LUI rd,hi.
  - Otherwise: LUI rd,hi then ADDI rd,rd,lo.
  - LI never raises range_err_o.

Optional Feature:
MIRISCV_IMM_ENC_CHECK_EN
- Defined:
  - range_err_o=1 when the immediate is not representable in its format:
    - I/S: imm not equal to sext(imm[11:0]).
    - B: imm[0]=1 or imm not equal to sext(imm[12:0]).
    - J: imm[0]=1 or imm not equal to sext(imm[20:0]).
    - U: imm[11:0] not zero.
  - The word is still emitted with the field truncated as above.
- Undefined: range_err_o is tied to 0 and no check logic is built. Encoding is identical.

Test Plan:
- ADDI: opcode OPIMM, rd=1, rs1=0, f3=0, imm=5 → instr_o=0x00500093 one cycle after accept, last=1, err=0.
- BEQ: opcode BRANCH, rs1=1, rs2=2, f3=0, imm=0xFFFFFFFC → instr_o=0xFE208EE3.
- LI two-word: rd=5, imm=0x12345FFF with instr_ready_i held 1 → 0x123462B7 (last=0), then next cycle 0xFFF28293 (last=1). req_ready_o is low while in LI_LO.
- LI single-word: imm=5, rd=5 → one word 0x00500293. imm=0x00010000, rd=5 → one word 0x000102B7. rd=0 → 0x00000013.
- Backpressure and reset: instr_ready_i=0 for 3 cycles during LI → LUI word held stable, no new accept. Assert rst_i while in LI_LO → valid=0 next edge, ADDI never emitted.
- Range, with CHECK_EN: OPIMM imm=0x800 → err=1, instr[31:20]=0x800. BRANCH imm=3 → err=1. Without CHECK_EN the same stimulus gives err=0 and identical instr_o.
